// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg
// Shared constants and types for the SPI-controlled PWM bank.
//   CMD_W      : width of the SPI command byte (write flag + 7-bit address)
//   CTRL_ADDR  : address of the control register
//   CTRL_EN    : control bit index, global output enable
//   CTRL_INV   : control bit index, global output invert
//   frame_len  : total SPI frame length in bits for a given data width
package spi_pwm_pkg;

   localparam int CMD_W = 8;
   localparam logic [6:0] CTRL_ADDR = 7'h7F;
   localparam int CTRL_EN = 0;
   localparam int CTRL_INV = 1;

   // Kind of frame in progress, known once the command byte is complete.
   typedef enum logic [1:0] {
      FRAME_IDLE,
      FRAME_WRITE,
      FRAME_READ
   } frame_kind_e;

   // A frame is the command byte followed by one data word.
   function automatic int frame_len(input int width);
      return CMD_W + width;
   endfunction

endpackage

// File: rtl/spi_frame_slave.sv
// spi_frame_slave
// Mode-0 SPI slave front end sampled in the clk domain. Synchronises the SPI
// pins, detects sclk edges, counts frame bits and assembles command/data.
//   clk, reset : system clock, synchronous active-high reset
//   sclk, cs, mosi : raw SPI pins (cs active-low)
//   miso       : registered serial read data, MSB first
//   wr_stb     : one-cycle pulse when a complete write frame arrives
//   rd_req     : one-cycle pulse when a read command byte completes
//   addr       : register address, valid with wr_stb and rd_req
//   data       : write data, valid with wr_stb
//   rd_data    : read value supplied by the register file alongside rd_req
module spi_frame_slave
   import spi_pwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   output logic             wr_stb,
   output logic             rd_req,
   output logic [6:0]       addr,
   output logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] rd_data
);

   localparam int FRAME = frame_len(WIDTH);
   localparam int CNT_W = $clog2(FRAME + 1);

   logic sclk_meta, sclk_sync, sclk_prev;
   logic cs_meta, cs_sync;
   logic mosi_meta, mosi_sync;

   logic [CNT_W-1:0] bit_cnt;
   logic [6:0]       cmd_sr;
   logic [WIDTH-2:0] data_sr;
   logic [WIDTH-1:0] out_buf;
   frame_kind_e      kind;
   logic             armed;

   logic             sclk_rise, sclk_fall, in_frame, cmd_last, data_last;
   logic [CMD_W-1:0] cmd_next;
   logic [WIDTH-1:0] data_next;

   // Two-flop synchronisers for every SPI pin plus a history flop on sclk.
   // cs idles high so a reset never looks like the start of a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         cs_meta   <= cs;
         cs_sync   <= cs_meta;
         mosi_meta <= mosi;
         mosi_sync <= mosi_meta;
      end
   end

   assign sclk_rise = sclk_sync & ~sclk_prev;
   assign sclk_fall = ~sclk_sync & sclk_prev;

   // After reset the slave only listens once cs has been seen high, so the
   // tail of a frame interrupted by reset is never mistaken for a new one.
   assign in_frame  = armed & ~cs_sync;

   assign cmd_next  = {cmd_sr, mosi_sync};
   assign data_next = {data_sr, mosi_sync};
   assign cmd_last  = in_frame & sclk_rise & (bit_cnt == CNT_W'(CMD_W - 1));
   assign data_last = in_frame & sclk_rise & (bit_cnt == CNT_W'(FRAME - 1))
                      & (kind == FRAME_WRITE);

   // While the last command bit arrives the address comes straight from the
   // shifter so a read can be answered on that same edge.
   assign addr   = cmd_last ? cmd_next[6:0] : cmd_sr;
   assign data   = data_next;
   assign wr_stb = data_last;
   assign rd_req = cmd_last & ~cmd_next[CMD_W-1];

   // Frame engine: the bit counter saturates at the frame length so extra
   // clocks are ignored; cs high clears everything, which discards partial
   // frames. Read data is shifted out on falling edges into a registered miso.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
         cmd_sr  <= '0;
         data_sr <= '0;
         out_buf <= '0;
         kind    <= FRAME_IDLE;
         armed   <= 1'b0;
         miso    <= 1'b0;
      end else if (!in_frame) begin
         bit_cnt <= '0;
         out_buf <= '0;
         kind    <= FRAME_IDLE;
         miso    <= 1'b0;
         if (cs_sync) begin
            armed <= 1'b1;
         end
      end else begin
         if (sclk_rise && (bit_cnt != CNT_W'(FRAME))) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt < CNT_W'(CMD_W)) begin
               cmd_sr <= cmd_next[6:0];
            end else begin
               data_sr <= data_next[WIDTH-2:0];
            end
            if (cmd_last) begin
               kind <= cmd_next[CMD_W-1] ? FRAME_WRITE : FRAME_READ;
               if (!cmd_next[CMD_W-1]) begin
                  out_buf <= rd_data;
               end
            end
         end
         if (sclk_fall && (kind == FRAME_READ)) begin
            miso    <= out_buf[WIDTH-1];
            out_buf <= {out_buf[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/spi_pwm_bank.sv
// spi_pwm_bank
// Bank of PWM channels configured over a mode-0 SPI slave port. Level writes
// land in a shadow register and are committed to the active level only at the
// end of a PWM period, so pulses never glitch.
//   CHANNELS, WIDTH : number of channels (1..127), level/counter width (2..16)
//   clk, reset      : system clock, synchronous active-high reset
//   sclk, cs, mosi  : SPI slave inputs (cs active-low)
//   miso            : SPI slave output
//   pwm_out         : registered PWM outputs, one per channel
module spi_pwm_bank
   import spi_pwm_pkg::*;
#(
   parameter int CHANNELS = 7,
   parameter int WIDTH    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sclk,
   input  logic                cs,
   input  logic                mosi,
   output logic                miso,
   output logic [CHANNELS-1:0] pwm_out
);

   // Last counter value of a period; the period is 2^WIDTH-1 clocks so a
   // full-scale level stays on for the whole period.
   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

   logic [WIDTH-1:0] shadow     [CHANNELS];
   logic [WIDTH-1:0] active_lvl [CHANNELS];
   logic [1:0]       ctrl;
   logic [WIDTH-1:0] counter;

   logic             wr_stb, rd_req;
   logic [6:0]       reg_addr;
   logic [WIDTH-1:0] wr_data, rd_data;

   spi_frame_slave #(
      .WIDTH(WIDTH)
   ) u_slave (
      .clk    (clk),
      .reset  (reset),
      .sclk   (sclk),
      .cs     (cs),
      .mosi   (mosi),
      .miso   (miso),
      .wr_stb (wr_stb),
      .rd_req (rd_req),
      .addr   (reg_addr),
      .data   (wr_data),
      .rd_data(rd_data)
   );

   // Register writes: channel levels go to the shadow copy, the control
   // register takes effect immediately. Unmapped addresses are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
         end
      end else if (wr_stb) begin
         if (reg_addr == CTRL_ADDR) begin
            ctrl <= wr_data[1:0];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (reg_addr == 7'(i)) begin
               shadow[i] <= wr_data;
            end
         end
      end
   end

   // Read-back returns the level actually in use, not a pending shadow.
   always_comb begin
      rd_data = '0;
      if (rd_req) begin
         if (reg_addr == CTRL_ADDR) begin
            rd_data = WIDTH'(ctrl);
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (reg_addr == 7'(i)) begin
               rd_data = active_lvl[i];
            end
         end
      end
   end

   // Period counter and commit. On the last count every shadow is copied to
   // its active level; a write landing in that same cycle only reaches the
   // shadow and therefore waits for the following wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            active_lvl[i] <= '0;
         end
      end else if (counter == CNT_LAST) begin
         counter <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            active_lvl[i] <= shadow[i];
         end
      end else begin
         counter <= counter + WIDTH'(1);
      end
   end

   // Output stage: compare, apply invert, gate with enable, then register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] <= ctrl[CTRL_EN]
                          & ((counter < active_lvl[i]) ^ ctrl[CTRL_INV]);
         end
      end
   end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// tb_spi_pwm_bank
// Directed plus randomised bench for spi_pwm_bank. A small model keeps the
// committed level of every channel and the control value; PWM outputs are
// judged by counting high cycles over whole periods, read-back by SPI reads.
module tb_spi_pwm_bank;
   import spi_pwm_pkg::*;

   localparam int CHANNELS = 7;
   localparam int WIDTH    = 8;
   localparam int PERIOD   = (1 << WIDTH) - 1;
   localparam int FRAME    = frame_len(WIDTH);
   localparam int HALF     = 6;
   localparam int SETTLE   = PERIOD + 15;

   logic clk = 1'b0;
   logic reset, sclk, cs, mosi;
   logic miso;
   logic [CHANNELS-1:0] pwm_out;

   int checks = 0;
   int errors = 0;
   int levelModel [CHANNELS];
   int ctrlModel;

   logic [WIDTH-1:0] rdBack;
   int runLen, lastRun, badRuns, saw64;
   logic inRun, prevBit;

   always #5 clk = ~clk;

   spi_pwm_bank #(
      .CHANNELS(CHANNELS),
      .WIDTH   (WIDTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sclk   (sclk),
      .cs     (cs),
      .mosi   (mosi),
      .miso   (miso),
      .pwm_out(pwm_out)
   );

   // One comparison: counts it and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic void resetModel();
      for (int i = 0; i < CHANNELS; i++) levelModel[i] = 0;
      ctrlModel = 0;
   endfunction

   function automatic int expectedRead(input int a);
      if (a < CHANNELS) return levelModel[a];
      if (a == 127) return ctrlModel;
      return 0;
   endfunction

   // High cycles a channel shows over the given number of whole periods.
   function automatic int expectedDuty(input int ch, input int periods);
      if ((ctrlModel & 1) == 0) return 0;
      if ((ctrlModel & 2) != 0) return periods * (PERIOD - levelModel[ch]);
      return periods * levelModel[ch];
   endfunction

   // Clocks nbits of a frame with cs already low. miso must stay low during
   // the command byte and throughout write frames; read data is collected at
   // each rising edge from the ninth on.
   task automatic clockBits(input logic [7:0] cmd, input logic [WIDTH-1:0] wdata,
                            input int nbits, output logic [WIDTH-1:0] rdata);
      logic [FRAME-1:0] frameBits;
      frameBits = {cmd, wdata};
      rdata = '0;
      for (int j = 0; j < nbits; j++) begin
         @(negedge clk);
         mosi = frameBits[FRAME-1-j];
         repeat (HALF) @(negedge clk);
         if (j < CMD_W) checkOutput("miso_cmd_phase", miso, 0);
         else if (cmd[7]) checkOutput("miso_write_frame", miso, 0);
         else rdata[WIDTH-1-(j-CMD_W)] = miso;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // One complete (or deliberately truncated) SPI frame.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [WIDTH-1:0] wdata,
                                input int nbits, output logic [WIDTH-1:0] rdata);
      @(negedge clk);
      cs = 1'b0;
      clockBits(cmd, wdata, nbits, rdata);
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic writeReg(input int a, input int val);
      logic [WIDTH-1:0] unused;
      applyStimulus({1'b1, 7'(a)}, WIDTH'(val), FRAME, unused);
      if (a < CHANNELS) levelModel[a] = val;
      else if (a == 127) ctrlModel = val & 3;
   endtask

   task automatic readCheck(input int a, input string tag);
      logic [WIDTH-1:0] rd;
      applyStimulus({1'b0, 7'(a)}, '0, FRAME, rd);
      checkOutput(tag, rd, expectedRead(a));
   endtask

   task automatic measureDuty(input int periods, input string tag);
      int counts [CHANNELS];
      for (int i = 0; i < CHANNELS; i++) counts[i] = 0;
      for (int c = 0; c < periods * PERIOD; c++) begin
         @(negedge clk);
         for (int i = 0; i < CHANNELS; i++) if (pwm_out[i] === 1'b1) counts[i]++;
      end
      for (int i = 0; i < CHANNELS; i++)
         checkOutput($sformatf("%s_ch%0d", tag, i), counts[i], expectedDuty(i, periods));
   endtask

   initial begin
      int ch, lvl, ua;
      reset = 1'b1;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      resetModel();
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_pwm_out", pwm_out, 0);
      checkOutput("reset_miso", miso, 0);
      readCheck(127, "reset_ctrl_read");

      $display("[TB] half-scale level on channel 0");
      writeReg(0, 8'h80);
      writeReg(127, 1);
      repeat (SETTLE) @(negedge clk);
      measureDuty(1, "duty_half");

      $display("[TB] zero and full-scale levels");
      writeReg(2, 8'h00);
      writeReg(3, 8'hFF);
      repeat (SETTLE) @(negedge clk);
      measureDuty(3, "duty_extremes");

      $display("[TB] mid-period level change on channel 1");
      writeReg(1, 8'h20);
      repeat (SETTLE) @(negedge clk);
      runLen = 0; lastRun = 0; badRuns = 0; saw64 = 0; inRun = 1'b0; prevBit = 1'b1;
      fork
         begin
            for (int c = 0; c < 4 * PERIOD; c++) begin
               @(negedge clk);
               if (pwm_out[1] && !prevBit) begin
                  inRun = 1'b1;
                  runLen = 1;
               end else if (pwm_out[1] && inRun) begin
                  runLen++;
               end else if (!pwm_out[1] && prevBit && inRun) begin
                  inRun = 1'b0;
                  lastRun = runLen;
                  if (runLen == 64) saw64 = 1;
                  else if (runLen != 32) badRuns++;
               end
               prevBit = pwm_out[1];
            end
         end
         begin
            repeat (100) @(negedge clk);
            writeReg(1, 8'h40);
         end
      join
      checkOutput("runt_pulses", badRuns, 0);
      checkOutput("new_pulse_seen", saw64, 1);
      checkOutput("last_pulse_len", lastRun, 64);

      $display("[TB] read-back");
      writeReg(5, 8'hA5);
      repeat (SETTLE) @(negedge clk);
      readCheck(5, "read_ch5");
      readCheck(16, "read_unmapped");
      readCheck(127, "read_ctrl");

      $display("[TB] aborted write");
      applyStimulus({1'b1, 7'd4}, 8'h5A, 12, rdBack);
      repeat (SETTLE) @(negedge clk);
      readCheck(4, "abort_ch4_kept");
      writeReg(4, 8'h5A);
      repeat (SETTLE) @(negedge clk);
      readCheck(4, "after_abort_ch4");

      $display("[TB] reset mid-frame");
      writeReg(127, 3);
      readCheck(127, "ctrl_before_reset");
      @(negedge clk);
      cs = 1'b0;
      clockBits({1'b0, 7'd3}, '0, 10, rdBack);
      repeat (4) @(negedge clk);
      checkOutput("miso_mid_read", miso, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("reset_mid_pwm_out", pwm_out, 0);
      checkOutput("reset_mid_miso", miso, 0);
      reset = 1'b0;
      resetModel();
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      readCheck(127, "ctrl_after_reset");
      readCheck(3, "ch3_after_reset");
      writeReg(6, 8'h77);
      repeat (SETTLE) @(negedge clk);
      readCheck(6, "frame_after_reset");

      $display("[TB] randomised levels and invert");
      for (int it = 0; it < 5; it++) begin
         ch  = $urandom_range(0, CHANNELS - 1);
         lvl = $urandom_range(0, PERIOD);
         writeReg(ch, lvl);
         writeReg(127, 1 | ($urandom_range(0, 1) << 1));
         repeat (SETTLE) @(negedge clk);
         measureDuty(1, $sformatf("rand%0d", it));
         ch = $urandom_range(0, CHANNELS - 1);
         readCheck(ch, $sformatf("rand%0d_read_ch%0d", it, ch));
         ua = $urandom_range(CHANNELS, 126);
         readCheck(ua, $sformatf("rand%0d_read_unmapped", it));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_pwm_bank.md
# spi_pwm_bank

Parametrised SPI-controlled PWM bank: N channels of W-bit pulse-width modulation, configured and read back over a mode-0 SPI slave port. Level writes are double-buffered and committed only at the PWM period boundary, so output pulses never glitch. It sits directly behind the chip's SPI pins and drives the PWM output pins.

## Interface
- `CHANNELS`, default 7: number of PWM channels, 1..127.
- `WIDTH`, default 8: level and counter width in bits, 2..16.
- `clk` input 1: system clock. Sole clock domain.
- `reset` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock, asynchronous to `clk`, mode 0 (CPOL=0, CPHA=0).
- `cs` input 1: SPI chip select, active-low, asynchronous.
- `mosi` input 1: SPI data in, MSB first.
- `miso` output 1: SPI data out, MSB first.
- `pwm_out` output CHANNELS: PWM outputs.

## Operation
- `sclk`, `cs` and `mosi` each pass through a 2-flop synchroniser. Edges are detected on the synchronised `sclk` against its previous value.
- Frame layout (8+WIDTH bits while `cs` is low): command byte then data.
  - Command byte: bit7 = write (1) / read (0); bits6:0 = address.
  - Data: WIDTH bits.
- Bits are sampled on rising `sclk` edges. A bit counter counts up from 0 and saturates at 8+WIDTH. Extra bits are ignored until `cs` rises.
- Address space:
  - 0..CHANNELS-1: channel level.
  - 0x7F: control register, bit0 = enable (reset 0), bit1 = invert (reset 0).
  - All other addresses: writes are dropped; reads return 0.
- Write: on the (8+WIDTH)-th rising edge, data goes into `shadow[addr]`. The control register is written immediately and has no shadow.
- Read: on the 8th rising edge, `out_buf` loads `active[addr]`, or the control value zero-extended. Each subsequent falling edge shifts `out_buf` left, and `miso` = `out_buf` MSB. The master samples data bit k on rising edge 9+k.
- `miso` = 0 when `cs` is high, during the command phase, and for write frames.
- If `cs` rises before the frame completes, the frame is discarded: no write, bit counter cleared.
- PWM counter:
  - Counts 0..2^WIDTH-2, then wraps to 0. The period is 2^WIDTH-1 clk.
  - Raw output = (counter < `active[i]`). A level of 0 is always off; a level of all-ones is always on.
  - `pwm_out[i]` = enable ? (raw XOR invert) : 0.
- Commit: in the cycle where counter == 2^WIDTH-2, `active[i]` <= `shadow[i]` for all channels.
  - If an SPI write lands in that same cycle, it updates the shadow only and goes active at the next wrap.
  - Back-to-back writes within one period: the last one wins.

## Timing
- Reset values: counter, all shadow and active levels, control, `out_buf` and bit counter = 0. `pwm_out` = 0 and `miso` = 0 from the first cycle after reset.
- Reset asserted mid-frame aborts the frame. The next frame begins at the first `cs` fall after reset deasserts.
- Edge latency: a pin change is seen by internal logic 3 clk later. `sclk` high and low phases must each be ≥ 4 clk.
- `miso` latency: updates 3 clk after the falling `sclk` pin edge.
- Write-to-output latency: from the final rising edge, at most 3 + (2^WIDTH-1) clk until the new level appears at a period start. A control write takes effect within 4 clk.
- `pwm_out` is registered: one clk after the counter/level compare.

## Structure
- Package `spi_pwm_pkg` holds:
  - `CMD_W = 8`, `CTRL_ADDR = 7'h7F`.
  - Control bit indices `CTRL_EN = 0`, `CTRL_INV = 1`.
  - The frame-length function `frame_len(WIDTH)`.
- Sub-module `spi_frame_slave`: synchronisers, edge detect, bit counter and shift registers. It emits a one-cycle `wr_stb` with `addr`/`data`, and a `rd_req` with `addr`, and accepts `rd_data`.
- The top level holds the register file, the counter, commit logic and output compare.

## Test plan
- Reset, then write ch0=0x80 and ctrl=0x01 → after the next wrap, `pwm_out[0]` is high for exactly 128 of every 255 clk; all other channels stay 0.
- Write ch2=0x00 and ch3=0xFF, enable → `pwm_out[2]` is constantly 0 and `pwm_out[3]` is constantly 1 across 3 periods.
- Write ch1=0x40 mid-period → `pwm_out[1]` is unchanged until the wrap, then the first new period is high for 64 clk with no runt pulse.
- Write ch5=0xA5, then read address 5 → `miso` shifts 1,0,1,0,0,1,0,1 on edges 9..16. Reading address 0x10 returns 0x00.
- Raise `cs` after 12 bits of a write to ch4 → ch4 is unchanged. A following full frame is accepted correctly.
- Assert `reset` mid-frame with ctrl=0x03 set → `pwm_out` = 0 and `miso` = 0 the next cycle, ctrl reads back 0x00, and a new frame works.
